// File: rtl/test_seq_gen.sv
// Burst stimulus generator: emits 'count' pkg::test_t symbols on a valid/ready
// stream, toggling the symbol through pkg::swap() after every 'run_len' accepts.
// Optional macro TEST_SEQ_GEN_ABORT_EN adds an 'abort' input that ends a burst early.
// The pkg package is defined here so the block compiles on its own.

package pkg;

   typedef enum logic {TEST_1, TEST_2} test_t;

   function automatic test_t swap(input test_t t);
      return (t == TEST_1) ? TEST_2 : TEST_1;
   endfunction

endpackage

module test_seq_gen #(
   parameter int unsigned LEN_W = 8,
   parameter int unsigned RUN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] count,
   input  logic [RUN_W-1:0] run_len,
   input  pkg::test_t       init,
`ifdef TEST_SEQ_GEN_ABORT_EN
   input  logic             abort,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output pkg::test_t       out_data,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

   state_e           state_q, state_d;
   logic             valid_q, valid_d;
   pkg::test_t       data_q, data_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
   logic [RUN_W-1:0] run_lim_q, run_lim_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept;
   logic             abort_req;

`ifdef TEST_SEQ_GEN_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   assign accept = valid_q & out_ready;

   // Next-state and registered-output computation
   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      data_d    = data_q;
      rem_d     = rem_q;
      run_cnt_d = run_cnt_q;
      run_lim_d = run_lim_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            busy_d  = 1'b0;
            valid_d = 1'b0;
            if (start) begin
               busy_d = 1'b1;
               if (count != '0) begin
                  state_d   = StEmit;
                  valid_d   = 1'b1;
                  rem_d     = count;
                  run_lim_d = (run_len == '0) ? RUN_W'(1) : run_len;
                  data_d    = init;
                  run_cnt_d = '0;
               end else begin
                  // Empty burst: straight to the done pulse, no symbol emitted
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end
         end
         StEmit: begin
            if (accept) begin
               rem_d = rem_q - LEN_W'(1);
               if (run_cnt_q == run_lim_q - RUN_W'(1)) begin
                  data_d    = pkg::swap(data_q);
                  run_cnt_d = '0;
               end else begin
                  run_cnt_d = run_cnt_q + RUN_W'(1);
               end
               if (rem_q == LEN_W'(1)) begin
                  valid_d = 1'b0;
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end
            // Abort wins over continuing; a coincident accept above still counts
            if (abort_req) begin
               valid_d = 1'b0;
               state_d = StDone;
               done_d  = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         valid_q   <= 1'b0;
         data_q    <= pkg::TEST_1;
         rem_q     <= '0;
         run_cnt_q <= '0;
         run_lim_q <= RUN_W'(1);
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         rem_q     <= rem_d;
         run_cnt_q <= run_cnt_d;
         run_lim_q <= run_lim_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_test_seq_gen.sv
// Directed self-checking bench for test_seq_gen.
module tb_test_seq_gen;

   localparam int unsigned LEN_W = 8;
   localparam int unsigned RUN_W = 4;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [LEN_W-1:0] count;
   logic [RUN_W-1:0] run_len;
   pkg::test_t       init;
   logic             abort;
   logic             out_valid;
   logic             out_ready;
   pkg::test_t       out_data;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_fail   = 0;

   test_seq_gen #(
      .LEN_W (LEN_W),
      .RUN_W (RUN_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .count     (count),
      .run_len   (run_len),
      .init      (init),
`ifdef TEST_SEQ_GEN_ABORT_EN
      .abort     (abort),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; count = '0; run_len = '0; init = pkg::TEST_2;
      out_ready = 1'b0; abort = 1'b0;
      repeat (3) step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
      n_checks++; if (out_data !== pkg::TEST_1) begin n_fail++; $display("FAIL reset_data got %0d want %0d", out_data, pkg::TEST_1); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      rst_n = 1'b1;
      repeat (3) step();
      n_checks++; if ({out_valid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL post_reset_idle got %b want 000", {out_valid, busy, done}); end
      n_checks++; if (out_data !== pkg::TEST_1) begin n_fail++; $display("FAIL post_reset_data got %0d want %0d", out_data, pkg::TEST_1); end
   endtask

   task automatic test_basic_toggle();
      pkg::test_t exp_seq [6];
      exp_seq = '{pkg::TEST_1, pkg::TEST_1, pkg::TEST_2, pkg::TEST_2, pkg::TEST_1, pkg::TEST_1};
      start = 1'b1; count = 8'd6; run_len = 4'd2; init = pkg::TEST_1; out_ready = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d] got v=%b b=%b want v=1 b=1", i, out_valid, busy); end
         n_checks++; if (out_data !== exp_seq[i]) begin n_fail++; $display("FAIL basic_data[%0d] got %0d want %0d", i, out_data, exp_seq[i]); end
         step();
      end
      n_checks++; if ({out_valid, busy, done} !== 3'b011) begin n_fail++; $display("FAIL basic_done got v,b,d=%b want 011", {out_valid, busy, done}); end
      step();
      n_checks++; if ({out_valid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL basic_idle got v,b,d=%b want 000", {out_valid, busy, done}); end
   endtask

   task automatic test_zero_cases();
      pkg::test_t exp_seq [3];
      exp_seq = '{pkg::TEST_2, pkg::TEST_1, pkg::TEST_2};
      // count = 0
      start = 1'b1; count = 8'd0; run_len = 4'd3; init = pkg::TEST_2; out_ready = 1'b1;
      step();
      start = 1'b0;
      n_checks++; if ({out_valid, busy, done} !== 3'b011) begin n_fail++; $display("FAIL zero_count_done got v,b,d=%b want 011", {out_valid, busy, done}); end
      step();
      n_checks++; if ({out_valid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL zero_count_idle got v,b,d=%b want 000", {out_valid, busy, done}); end
      // run_len = 0 behaves as 1
      start = 1'b1; count = 8'd3; run_len = 4'd0; init = pkg::TEST_2;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin n_fail++; $display("FAIL runlen0_data[%0d] got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, exp_seq[i]); end
         step();
      end
      n_checks++; if ({out_valid, done} !== 2'b01) begin n_fail++; $display("FAIL runlen0_done got v,d=%b want 01", {out_valid, done}); end
      step();
   endtask

   task automatic test_backpressure();
      pkg::test_t exp_seq [4];
      pkg::test_t stall_data;
      logic stalled;
      logic got_done;
      int n_acc;
      exp_seq = '{pkg::TEST_1, pkg::TEST_2, pkg::TEST_1, pkg::TEST_2};
      stalled = 1'b0; got_done = 1'b0; n_acc = 0; stall_data = pkg::TEST_1;
      start = 1'b1; count = 8'd4; run_len = 4'd1; init = pkg::TEST_1; out_ready = 1'b0;
      step();
      for (int i = 0; i < 200; i++) begin
         if (done) begin got_done = 1'b1; break; end
         out_ready = (i < 2) ? 1'b0 : 1'($urandom_range(0, 1));
         // Second start mid-burst must be ignored
         start = (i == 2) ? 1'b1 : 1'b0;
         count = 8'd7; init = pkg::TEST_2;
         if (stalled) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== stall_data) begin n_fail++; $display("FAIL bp_stable got v=%b d=%0d want v=1 d=%0d", out_valid, out_data, stall_data); end
         end
         if (out_valid) begin
            if (out_ready) begin
               if (n_acc < 4) begin
                  n_checks++; if (out_data !== exp_seq[n_acc]) begin n_fail++; $display("FAIL bp_data[%0d] got %0d want %0d", n_acc, out_data, exp_seq[n_acc]); end
               end
               n_acc++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               stall_data = out_data;
            end
         end
         step();
      end
      start = 1'b0; out_ready = 1'b1;
      n_checks++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got done=%b want 1", got_done); end
      n_checks++; if (n_acc != 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", n_acc); end
      step();
      repeat (3) step();
      n_checks++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL bp_ignored_start got v,b=%b want 00", {out_valid, busy}); end
   endtask

   task automatic test_reset_mid_burst();
      logic got_done;
      logic saw_done;
      int n_acc;
      got_done = 1'b0; saw_done = 1'b0; n_acc = 0;
      start = 1'b1; count = 8'd10; run_len = 4'd1; init = pkg::TEST_1; out_ready = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      n_checks++; if ({out_valid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL midrst_immediate got v,b,d=%b want 000", {out_valid, busy, done}); end
      n_checks++; if (out_data !== pkg::TEST_1) begin n_fail++; $display("FAIL midrst_data got %0d want %0d", out_data, pkg::TEST_1); end
      for (int i = 0; i < 3; i++) begin
         step();
         if (done) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      step();
      if (done) saw_done = 1'b1;
      n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done got %b want 0", saw_done); end
      start = 1'b1; count = 8'd2; run_len = 4'd3; init = pkg::TEST_2;
      step();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin got_done = 1'b1; break; end
         if (out_valid) begin
            n_checks++; if (out_data !== pkg::TEST_2) begin n_fail++; $display("FAIL midrst_new_data[%0d] got %0d want %0d", n_acc, out_data, pkg::TEST_2); end
            n_acc++;
         end
         step();
      end
      n_checks++; if (got_done !== 1'b1 || n_acc != 2) begin n_fail++; $display("FAIL midrst_new_count got done=%b n=%0d want done=1 n=2", got_done, n_acc); end
      step();
   endtask

`ifdef TEST_SEQ_GEN_ABORT_EN
   task automatic test_abort();
      pkg::test_t exp_seq [3];
      exp_seq = '{pkg::TEST_1, pkg::TEST_1, pkg::TEST_2};
      start = 1'b1; count = 8'd8; run_len = 4'd2; init = pkg::TEST_1; out_ready = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         abort = (i == 2) ? 1'b1 : 1'b0;
         n_checks++; if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin n_fail++; $display("FAIL abort_data[%0d] got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, exp_seq[i]); end
         step();
      end
      abort = 1'b0;
      n_checks++; if ({out_valid, busy, done} !== 3'b011) begin n_fail++; $display("FAIL abort_done got v,b,d=%b want 011", {out_valid, busy, done}); end
      step();
      n_checks++; if ({out_valid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL abort_idle got v,b,d=%b want 000", {out_valid, busy, done}); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_toggle();
      test_zero_cases();
      test_backpressure();
      test_reset_mid_burst();
`ifdef TEST_SEQ_GEN_ABORT_EN
      test_abort();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/test_seq_gen.md
Name: test_seq_gen

Overview:
Upstream stimulus stage for the `pkg::swap` combinational stage. It emits a burst of `pkg::test_t` symbols over a valid/ready stream. The symbol toggles via `pkg::swap()` after every `run_len` accepted symbols. The output stream feeds the swap stage input, or any other `pkg::test_t` consumer.

Parameters:
- LEN_W, 8, width of the burst length (max burst 2^LEN_W-1 symbols)
- RUN_W, 4, width of the run-length field (symbols per run before toggling)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  burst request, sampled in IDLE only
- count  input  LEN_W  total symbols in burst, latched on start
- run_len  input  RUN_W  symbols per run, latched on start; 0 treated as 1
- init  input  pkg::test_t  first symbol of burst, latched on start
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- out_data  output  pkg::test_t  current symbol
- busy  output  1  high in EMIT and DONE
- done  output  1  one-cycle pulse at burst end

Behaviour:
- Reset (async assert, sync release): state IDLE; out_valid=0; out_data=TEST_1; busy=0; done=0; remaining=0; run_cnt=0.
- States: IDLE, EMIT, DONE. All outputs are registered.
- IDLE, start=1, count!=0:
  - latch remaining=count, run_lim=max(run_len,1), out_data=init, run_cnt=0.
  - next cycle: state EMIT, out_valid=1, busy=1.
- IDLE, start=1, count=0: go to DONE; out_valid never asserts.
- Accept = out_valid && out_ready. No symbol is duplicated or skipped.
- EMIT, on accept:
  - remaining decrements.
  - if run_cnt==run_lim-1: out_data <= pkg::swap(out_data), run_cnt <= 0; else run_cnt++.
  - if remaining==1 (last symbol): out_valid <= 0, state DONE.
  - otherwise out_valid stays 1. Back-to-back acceptance gives 1 symbol/cycle.
- EMIT, out_valid=1 and out_ready=0: out_data, out_valid, counters all hold (AXI-style stability).
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE with busy=0.
- start while busy=1: ignored, no latch.
- Latency: start to first out_valid = 1 cycle. Last accept to done = 1 cycle.
- Burst length exactly count; out_data after the last accept is don't-care but must remain a legal enum value.
- Toggle on run boundary only, including when run_lim=1 (toggle every symbol).
- Reset mid-burst: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: TEST_SEQ_GEN_ABORT_EN.
- Defined:
  - adds port `abort  input  1`.
  - abort=1 in EMIT ends the burst: out_valid=0 next cycle, state DONE, done pulses.
  - if accept coincides with abort, that symbol counts as delivered.
  - abort is ignored in IDLE and DONE.
- Undefined: port absent; behaviour exactly as above.

Test Plan:
- Reset: hold rst_n=0 with clk running -> out_valid=0, out_data=TEST_1, busy=0, done=0; deassert -> all hold until start.
- Basic toggle: start, count=6, run_len=2, init=TEST_1, out_ready=1 -> out_data T1,T1,T2,T2,T1,T1 on 6 consecutive cycles; done 1 cycle after 6th; busy low next cycle.
- Zero edge cases: count=0 -> no out_valid, done pulse 1 cycle after start. run_len=0, count=3, init=TEST_2 -> T2,T1,T2.
- Backpressure: count=4, run_len=1, out_ready random 50% -> data stable while stalled; accepted sequence T1,T2,T1,T2; start during burst ignored.
- Reset mid-burst: count=10; rst_n low after 3 accepts -> out_valid=0 immediately, no done; new start with count=2 delivers exactly 2.
- Abort (TEST_SEQ_GEN_ABORT_EN): count=8, abort with the 3rd accept -> exactly 3 symbols delivered, done next cycle.
